ram_tdp_be_clr: RTL and testbench
=================================

Name: ram_tdp_be_clr

Overview:
True dual-port, byte-writable block RAM of configurable width and depth, zero-initialised at configuration time. It is the parametrised successor of our fixed write-first dual-port RAM. It adds:
- per-port enable
- byte write enables
- selectable write mode
- optional output pipeline register
- a run-time clear sequencer that re-zeroes the whole array on request
Used for caches, TLB tags and scratchpads where a fast flush is needed.

Parameters:
DATA_WIDTH, 32, word width in bits; must be a multiple of BYTE_WIDTH
ADDR_WIDTH, 10, address bits; depth = 2^ADDR_WIDTH, ADDR_WIDTH >= 1
BYTE_WIDTH, 8, bits per byte-enable lane; NB = DATA_WIDTH/BYTE_WIDTH
WRITE_MODE, 0, 0 = write-first, 1 = read-first, 2 = no-change (applies to both ports)
OUT_REG, 0, 1 = extra output register stage (read latency 2 instead of 1)

Ports:
clk  in  1  single clock; all logic on the rising edge
rst  in  1  synchronous, active-high reset
clr  in  1  single-cycle pulse that starts a full-array clear
busy  out  1  high while the clear sequencer runs
ena  in  1  port A enable
wea  in  NB  port A byte write enables
addra  in  ADDR_WIDTH  port A address
dina  in  DATA_WIDTH  port A write data
douta  out  DATA_WIDTH  port A read data
enb  in  1  port B enable
web  in  NB  port B byte write enables
addrb  in  ADDR_WIDTH  port B address
dinb  in  DATA_WIDTH  port B write data
doutb  out  DATA_WIDTH  port B read data
collision  out  1  registered flag: the previous cycle had both ports enabled, the same address, and at least one port writing

Behaviour:
- Array is all zeros after configuration. rst does not touch array contents.
- rst: on the next edge, douta, doutb, collision, both pipeline stages and busy go to 0; the sequencer returns to IDLE. A reset during a clear aborts it, leaving the array partially cleared; no resume.
- Port access (IDLE state, enX=1): at edge N, byte lane k of the word is written from dinX when weX[k]=1.
- Port read data, OUT_REG=0, valid after edge N:
  - write-first: the new merged word (written lanes new, others old)
  - read-first: the old word
  - no-change: doutX holds its previous value when any weX bit is 1; with weX all zero, the stored word
- OUT_REG=1: the same values appear one edge later (edge N+1).
- enX=0: no write; the first-stage output holds; the pipeline stage keeps shifting.
- Same-address collision:
  - Both ports writing: for each lane both write, port B wins; lanes written by only one port take that port's data.
  - One port writes, the other reads: the reader's value is the old word in all modes.
  - collision asserts for one cycle after the event.
- Clear FSM, states IDLE and CLEAR:
  - IDLE -> CLEAR on clr=1 and rst=0. busy rises on that edge.
  - In CLEAR, port A writes 0 to even address 2i and port B writes 0 to odd address 2i+1. Counter i runs 0 .. 2^(ADDR_WIDTH-1)-1, so the clear takes 2^(ADDR_WIDTH-1) cycles.
  - CLEAR -> IDLE after the last pair; busy falls on the same edge as the last write.
  - While busy=1: user en/we/clr are ignored, douta/doutb hold 0, and collision stays 0.
  - clr while busy is ignored.
- User traffic is accepted again on the first edge with busy=0.
- Widths: the counter is ADDR_WIDTH-1 bits and does not wrap past its terminal count.

Test Plan:
- Write-first, OUT_REG=0: A writes 0xDEADBEEF to addr 5, wea=4'hF; next cycle read addr 5 -> douta=0xDEADBEEF one edge after each access; B reads addr 5 -> 0xDEADBEEF.
- Byte enables: word at 3 is 0x11223344; write 0xAABBCCDD with wea=4'b0101 -> read 0x11BB33DD. Repeat in read-first: the write cycle returns 0x11223344.
- OUT_REG=1, no-change: write at 7 -> douta unchanged for 2 edges; read 7 -> data after 2 edges.
- Collision: A and B both write addr 9 (A=0x1, B=0x2, full enables) -> addr 9 = 0x2; collision=1 for exactly one cycle. A writes 9 while B reads 9 -> doutb = old value.
- Clear, ADDR_WIDTH=4: fill all 16 words with 0xFFFFFFFF; pulse clr -> busy high for exactly 8 cycles; user writes during busy are dropped; then all 16 words read 0.
- Reset mid-clear (ADDR_WIDTH=4): rst after 3 clear cycles -> busy=0 and outputs 0 next edge; addrs 0-5 read 0, addrs 6-15 keep 0xFFFFFFFF.

Source files
------------

// File: rtl/ram_tdp_be_clr.sv
// ram_tdp_be_clr: true dual-port byte-writable RAM with write modes, optional output register and a run-time clear sequencer
module ram_tdp_be_clr #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 10,
  parameter int BYTE_WIDTH = 8,
  parameter int WRITE_MODE = 0,
  parameter int OUT_REG    = 0,
  localparam int NB        = DATA_WIDTH / BYTE_WIDTH
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  clr,
  output logic                  busy,
  input  logic                  ena,
  input  logic [NB-1:0]         wea,
  input  logic [ADDR_WIDTH-1:0] addra,
  input  logic [DATA_WIDTH-1:0] dina,
  output logic [DATA_WIDTH-1:0] douta,
  input  logic                  enb,
  input  logic [NB-1:0]         web,
  input  logic [ADDR_WIDTH-1:0] addrb,
  input  logic [DATA_WIDTH-1:0] dinb,
  output logic [DATA_WIDTH-1:0] doutb,
  output logic                  collision
);
  localparam int DEPTH = 1 << ADDR_WIDTH;
  localparam int CW = ADDR_WIDTH > 1 ? ADDR_WIDTH - 1 : 1;
  localparam logic [CW-1:0] LAST = CW'(DEPTH / 2 - 1);
  typedef enum logic {IDLE, CLEAR} state_t;
  state_t state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [DATA_WIDTH-1:0] mem [DEPTH] = '{default: '0};
  logic idle, quiet;
  logic [NB-1:0] wa, wb;
  logic [ADDR_WIDTH-1:0] clr_addr;
  logic [DATA_WIDTH-1:0] old_a, old_b, mrg_a, mrg_b;
  logic [DATA_WIDTH-1:0] da1_q, da1_d, db1_q, db1_d, da2_q, da2_d, db2_q, db2_d;
  logic col_q, col_d;

  function automatic logic [DATA_WIDTH-1:0] rd(input logic [DATA_WIDTH-1:0] hold, old, mrg, input logic wr);
    return (WRITE_MODE == 0 && wr) ? mrg : (WRITE_MODE == 2 && wr) ? hold : old;
  endfunction

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      da1_q   <= '0;
      db1_q   <= '0;
      da2_q   <= '0;
      db2_q   <= '0;
      col_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      da1_q   <= da1_d;
      db1_q   <= db1_d;
      da2_q   <= da2_d;
      db2_q   <= db2_d;
      col_q   <= col_d;
    end
  end

  always_comb begin
    idle    = state_q == IDLE;
    state_d = idle ? (clr ? CLEAR : IDLE) : (cnt_q == LAST ? IDLE : CLEAR);
    cnt_d   = idle ? '0 : (cnt_q == LAST ? cnt_q : cnt_q + CW'(1));
  end

  always_comb begin
    busy      = !idle;
    quiet     = !idle || clr;
    clr_addr  = ADDR_WIDTH'({cnt_q, 1'b0});
    wa        = (idle && ena) ? wea : '0;
    wb        = (idle && enb) ? web : '0;
    old_a     = mem[addra];
    old_b     = mem[addrb];
    mrg_a     = old_a;
    mrg_b     = old_b;
    for (int k = 0; k < NB; k++) begin
      if (wea[k]) mrg_a[k*BYTE_WIDTH +: BYTE_WIDTH] = dina[k*BYTE_WIDTH +: BYTE_WIDTH];
      if (web[k]) mrg_b[k*BYTE_WIDTH +: BYTE_WIDTH] = dinb[k*BYTE_WIDTH +: BYTE_WIDTH];
    end
    da1_d     = quiet ? '0 : !ena ? da1_q : rd(da1_q, old_a, mrg_a, |wea);
    db1_d     = quiet ? '0 : !enb ? db1_q : rd(db1_q, old_b, mrg_b, |web);
    da2_d     = quiet ? '0 : da1_q;
    db2_d     = quiet ? '0 : db1_q;
    col_d     = !quiet && ena && enb && addra == addrb && (|wea || |web);
    douta     = OUT_REG != 0 ? da2_q : da1_q;
    doutb     = OUT_REG != 0 ? db2_q : db1_q;
    collision = col_q;
  end

  // Port B's lane writes come after port A's, so B wins on a same-address lane clash
  always_ff @(posedge clk) begin
    if (!idle && !rst) begin
      mem[clr_addr]                     <= '0;
      mem[clr_addr | ADDR_WIDTH'(1)]    <= '0;
    end
    for (int k = 0; k < NB; k++) begin
      if (wa[k]) mem[addra][k*BYTE_WIDTH +: BYTE_WIDTH] <= dina[k*BYTE_WIDTH +: BYTE_WIDTH];
      if (wb[k]) mem[addrb][k*BYTE_WIDTH +: BYTE_WIDTH] <= dinb[k*BYTE_WIDTH +: BYTE_WIDTH];
    end
  end
endmodule

// File: tb/tb_ram_tdp_be_clr.sv
// tb_ram_tdp_be_clr: three RAM variants (write-first, read-first, no-change+out reg) on shared stimulus vs a word-level model
module tb_ram_tdp_be_clr;
  logic clk = 1'b0;
  logic rst, clr, ena, enb;
  logic [3:0] wea, web;
  logic [3:0] addra, addrb;
  logic [31:0] dina, dinb;
  logic [31:0] douta [3];
  logic [31:0] doutb [3];
  logic busy [3];
  logic col [3];
  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  for (genvar g = 0; g < 3; g++) begin : g_dut
    ram_tdp_be_clr #(.DATA_WIDTH(32), .ADDR_WIDTH(4), .BYTE_WIDTH(8), .WRITE_MODE(g), .OUT_REG(g == 2 ? 1 : 0)) u_dut (
      .clk(clk), .rst(rst), .clr(clr), .busy(busy[g]),
      .ena(ena), .wea(wea), .addra(addra), .dina(dina), .douta(douta[g]),
      .enb(enb), .web(web), .addrb(addrb), .dinb(dinb), .doutb(doutb[g]),
      .collision(col[g])
    );
  end

  // Reference model: memory contents, clear progress and expected outputs
  logic [31:0] m_mem [16];
  logic [31:0] e1a [3], e1b [3], eoa [3], eob [3];
  bit m_busy = 0;
  int m_cnt = 0;
  bit e_col = 0;

  function automatic logic [31:0] merge(input logic [31:0] old, din, input logic [3:0] we);
    logic [31:0] r = old;
    for (int k = 0; k < 4; k++) if (we[k]) r[8*k +: 8] = din[8*k +: 8];
    return r;
  endfunction

  function automatic logic [31:0] first(input int mode, input logic en, input logic [3:0] we, input logic [31:0] old, din, hold);
    if (!en) return hold;
    if (we == 0) return old;
    return mode == 0 ? merge(old, din, we) : mode == 1 ? old : hold;
  endfunction

  task automatic model_edge();
    logic [31:0] oa, ob, s2a, s2b;
    bit quiet;
    if (rst) begin
      for (int i = 0; i < 3; i++) begin e1a[i] = 0; e1b[i] = 0; eoa[i] = 0; eob[i] = 0; end
      m_busy = 0;
      e_col = 0;
      return;
    end
    quiet = m_busy || clr;
    s2a = quiet ? 32'h0 : e1a[2];
    s2b = quiet ? 32'h0 : e1b[2];
    if (m_busy) begin
      m_mem[2*m_cnt] = 0;
      m_mem[2*m_cnt+1] = 0;
      m_cnt++;
      if (m_cnt == 8) m_busy = 0;
      for (int i = 0; i < 3; i++) begin e1a[i] = 0; e1b[i] = 0; end
      e_col = 0;
    end else begin
      oa = m_mem[addra];
      ob = m_mem[addrb];
      for (int i = 0; i < 3; i++) begin
        e1a[i] = clr ? 32'h0 : first(i, ena, wea, oa, dina, e1a[i]);
        e1b[i] = clr ? 32'h0 : first(i, enb, web, ob, dinb, e1b[i]);
      end
      e_col = !clr && ena && enb && addra == addrb && (wea != 0 || web != 0);
      if (ena) m_mem[addra] = merge(m_mem[addra], dina, wea);
      if (enb) m_mem[addrb] = merge(m_mem[addrb], dinb, web);
      if (clr) begin m_busy = 1; m_cnt = 0; end
    end
    for (int i = 0; i < 2; i++) begin eoa[i] = e1a[i]; eob[i] = e1b[i]; end
    eoa[2] = s2a;
    eob[2] = s2b;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    model_edge();
    #1;
    for (int i = 0; i < 3; i++) begin
      chk($sformatf("douta[%0d]", i), douta[i], eoa[i]);
      chk($sformatf("doutb[%0d]", i), doutb[i], eob[i]);
      chk($sformatf("busy[%0d]", i), 32'(busy[i]), 32'(m_busy));
      chk($sformatf("collision[%0d]", i), 32'(col[i]), 32'(e_col));
    end
  endtask

  task automatic set_a(input logic en, input logic [3:0] we, addr, input logic [31:0] din);
    ena = en; wea = we; addra = addr; dina = din;
  endtask

  task automatic set_b(input logic en, input logic [3:0] we, addr, input logic [31:0] din);
    enb = en; web = we; addrb = addr; dinb = din;
  endtask

  task automatic quiet_ports();
    set_a(0, 0, 0, 0);
    set_b(0, 0, 0, 0);
    clr = 0;
  endtask

  task automatic rand_ports();
    set_a(1'($urandom), $urandom_range(0, 1) ? 4'($urandom) : 4'h0, 4'($urandom_range(0, 3)), $urandom);
    set_b(1'($urandom), $urandom_range(0, 1) ? 4'($urandom) : 4'h0, 4'($urandom_range(0, 3)), $urandom);
  endtask

  task automatic fill_ones();
    for (int i = 0; i < 8; i++) begin
      set_a(1, 4'hF, 4'(2*i), 32'hFFFF_FFFF);
      set_b(1, 4'hF, 4'(2*i+1), 32'hFFFF_FFFF);
      cyc();
    end
    quiet_ports();
  endtask

  initial begin
    int n;
    for (int i = 0; i < 16; i++) m_mem[i] = 0;
    for (int i = 0; i < 3; i++) begin e1a[i] = 0; e1b[i] = 0; eoa[i] = 0; eob[i] = 0; end
    rst = 1;
    quiet_ports();
    cyc();
    cyc();
    rst = 0;
    set_a(1, 4'hF, 5, 32'hDEAD_BEEF);
    cyc();
    chk("wf_write_5", douta[0], 32'hDEAD_BEEF);
    set_a(1, 0, 5, 0);
    set_b(1, 0, 5, 0);
    cyc();
    chk("wf_read_a5", douta[0], 32'hDEAD_BEEF);
    chk("wf_read_b5", doutb[0], 32'hDEAD_BEEF);
    quiet_ports();
    set_a(1, 4'hF, 3, 32'h1122_3344);
    cyc();
    set_a(1, 4'b0101, 3, 32'hAABB_CCDD);
    cyc();
    chk("be_wf_write", douta[0], 32'h11BB_33DD);
    chk("be_rf_write", douta[1], 32'h1122_3344);
    set_a(1, 0, 3, 0);
    cyc();
    chk("be_read_3", douta[0], 32'h11BB_33DD);
    set_a(1, 4'hF, 7, 32'hCAFE_F00D);
    cyc();
    chk("nc_hold_1", douta[2], 32'h11BB_33DD);
    set_a(1, 0, 7, 0);
    cyc();
    chk("nc_hold_2", douta[2], 32'h11BB_33DD);
    quiet_ports();
    cyc();
    chk("nc_read_7", douta[2], 32'hCAFE_F00D);
    set_a(1, 4'hF, 9, 32'h1);
    set_b(1, 4'hF, 9, 32'h2);
    cyc();
    chk("col_pulse", 32'(col[0]), 32'h1);
    quiet_ports();
    cyc();
    chk("col_drop", 32'(col[0]), 32'h0);
    set_a(1, 0, 9, 0);
    cyc();
    chk("col_b_wins", douta[0], 32'h2);
    set_a(1, 4'hF, 9, 32'h5);
    set_b(1, 0, 9, 0);
    cyc();
    chk("col_reader_old", doutb[0], 32'h2);
    for (int i = 0; i < 300; i++) begin
      rand_ports();
      cyc();
    end
    quiet_ports();
    fill_ones();
    clr = 1;
    cyc();
    chk("clr_busy_rise", 32'(busy[0]), 32'h1);
    n = 0;
    while (busy[0] && n < 20) begin
      n++;
      rand_ports();
      clr = 1'($urandom);
      cyc();
    end
    chk("clr_busy_len", 32'(n), 32'd8);
    quiet_ports();
    for (int i = 0; i < 8; i++) begin
      set_a(1, 0, 4'(2*i), 0);
      set_b(1, 0, 4'(2*i+1), 0);
      cyc();
      chk("clr_read_a", douta[0], 32'h0);
      chk("clr_read_b", doutb[0], 32'h0);
    end
    quiet_ports();
    fill_ones();
    clr = 1;
    cyc();
    clr = 0;
    cyc();
    cyc();
    cyc();
    rst = 1;
    cyc();
    chk("abort_busy", 32'(busy[0]), 32'h0);
    rst = 0;
    for (int i = 0; i < 8; i++) begin
      set_a(1, 0, 4'(2*i), 0);
      set_b(1, 0, 4'(2*i+1), 0);
      cyc();
      chk("abort_read_a", douta[0], 2*i < 6 ? 32'h0 : 32'hFFFF_FFFF);
      chk("abort_read_b", doutb[0], 2*i+1 < 6 ? 32'h0 : 32'hFFFF_FFFF);
    end
    quiet_ports();
    cyc();
    cyc();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
